// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes, opcodes, instruction fields.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_W = 16;
  localparam int IDX_W = 3;

  typedef enum logic [3:0] {
    ALU_NAND = 4'd0,
    ALU_AND  = 4'd1,
    ALU_NOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SL   = 4'd7,
    ALU_SR   = 4'd8
  } alu_func_e;

  // Opcodes 0-8 share their encoding with alu_func_e; 10-15 are illegal.
  localparam logic [3:0] OP_NAND = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SL   = 4'd7;
  localparam logic [3:0] OP_SR   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;

  // Instruction field positions. rs2 and imm6 overlap.
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [3:0]       op;
    logic [IDX_W-1:0] rd;
    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic [5:0]       imm6;
  } instr_t;

  function automatic instr_t decode(input logic [REG_W-1:0] raw);
    instr_t d;
    d.op   = raw[OP_HI:OP_LO];
    d.rd   = raw[RD_HI:RD_LO];
    d.rs1  = raw[RS1_HI:RS1_LO];
    d.rs2  = raw[RS2_HI:RS2_LO];
    d.imm6 = raw[IMM_HI:IMM_LO];
    return d;
  endfunction

  function automatic logic [REG_W-1:0] sext6(input logic [5:0] v);
    return {{(REG_W-6){v[5]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: 2 combinational reads, 1 synchronous write, R0 reads 0.
// Latency: reads 0 cycles; a write is visible to reads after the next rising edge.
// Backpressure: none; a write is always accepted (writes to R0 dropped).
// Ports: clk/rst; ra1/rd1 and ra2/rd2 read ports; we/wa/wd write port.
module regfile
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] ra1,
  output logic [REG_W-1:0] rd1,
  input  logic [IDX_W-1:0] ra2,
  output logic [REG_W-1:0] rd2,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [REG_W-1:0] wd
);

  logic [REG_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: decode, scoreboard hazard check, register read with writeback bypass, issue.
// Latency: 1 cycle from accepted instruction to out_valid.
// Backpressure: in_ready drops on a held output (out_valid & ~out_ready) or a RAW/WAW hazard.
// Ports: clk/rst; in_valid/in_ready/in_instr from fetch; out_valid/out_ready and
//   out_alu_func/out_a/out_b/out_rd to execute; wb_valid/wb_rd/wb_data from execute;
//   illegal is a sticky bad-opcode flag.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_func_e        out_alu_func,
  output logic [REG_W-1:0] out_a,
  output logic [REG_W-1:0] out_b,
  output logic [IDX_W-1:0] out_rd,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic [REG_W-1:0] wb_data,
  output logic             illegal
);

  instr_t           d;
  logic             is_imm;
  logic             is_illegal;
  logic             uses_rs2;
  logic             wb_live;
  logic [REG_W-1:0] rf_a;
  logic [REG_W-1:0] rf_b;
  logic [REG_W-1:0] src_a;
  logic [REG_W-1:0] src_b;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] pend_eff;
  logic [NREGS-1:0] rd_set;
  logic             hazard;
  logic             xfer;
  logic             issue;
  alu_func_e        func;

  assign d          = decode(in_instr);
  assign is_imm     = (d.op == OP_ADDI);
  assign is_illegal = (d.op > OP_ADDI);
  assign uses_rs2   = (d.op < OP_ADDI);

  // R0 writebacks are dropped everywhere: regfile, bypass and scoreboard.
  assign wb_live = wb_valid && (wb_rd != '0);

  regfile #(.NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (d.rs1),
    .rd1 (rf_a),
    .ra2 (d.rs2),
    .rd2 (rf_b),
    .we  (wb_valid),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // Same-cycle writeback forwarding; the regfile only sees it next edge.
  assign src_a = (wb_live && (wb_rd == d.rs1)) ? wb_data : rf_a;
  assign src_b = is_imm                         ? sext6(d.imm6) :
                 (wb_live && (wb_rd == d.rs2))  ? wb_data       : rf_b;

  assign func = is_imm ? ALU_ADD : alu_func_e'(d.op);

  // Hazard is evaluated after this cycle's writeback clear so a stalled
  // consumer is released in the same cycle its producer writes back.
  assign wb_clr   = wb_live ? (NREGS'(1) << wb_rd) : '0;
  assign pend_eff = pending & ~wb_clr;
  assign hazard   = in_valid & (pend_eff[d.rs1] |
                                (uses_rs2 & pend_eff[d.rs2]) |
                                pend_eff[d.rd]);

  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign xfer     = in_valid & in_ready;
  assign issue    = xfer & ~is_illegal;

  // Set is OR-ed after the clear, so accept-rd==wb_rd leaves the bit set.
  assign rd_set = (issue && (d.rd != '0)) ? (NREGS'(1) << d.rd) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      out_valid    <= 1'b0;
      out_alu_func <= ALU_NAND;
      out_a        <= '0;
      out_b        <= '0;
      out_rd       <= '0;
      illegal      <= 1'b0;
    end else begin
      pending <= pend_eff | rd_set;
      if (xfer && is_illegal) begin
        illegal <= 1'b1;
      end
      if (issue) begin
        out_valid    <= 1'b1;
        out_alu_func <= func;
        out_a        <= src_a;
        out_b        <= src_b;
        out_rd       <= d.rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed vectors, queue-based scoreboard.
// Latency: n/a.
// Backpressure: exercised by driving out_ready low while outputs are pending.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  alu_func_e   out_alu_func;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_rd;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal;

  operand_fetch #(.NREGS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_func (out_alu_func),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    alu_func_e   func;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   w;

  function automatic exp_t mk(alu_func_e f, logic [15:0] a, logic [15:0] b, logic [2:0] rd);
    exp_t e;
    e.func = f;
    e.a    = a;
    e.b    = b;
    e.rd   = rd;
    return e;
  endfunction

  function automatic logic [15:0] enc_r(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [5:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until accepted (bounded); leaves in_valid asserted.
  task automatic send(input logic [15:0] ins, input bit has_out, input exp_t e, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int c = 0; c <= 20 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (has_out) exp_q.push_back(e);
      end else begin
        waited++;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!ok) in_valid = 1'b0;
  endtask

  // Monitor: every output handshake pops the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue: unexpected output func=%0d a=0x%0h b=0x%0h rd=%0d",
                 out_alu_func, out_a, out_b, out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({out_alu_func, out_a, out_b, out_rd} !== {e.func, e.a, e.b, e.rd}) begin
          bad++;
          $display("FAIL issue: got func=%0d a=0x%0h b=0x%0h rd=%0d, want func=%0d a=0x%0h b=0x%0h rd=%0d",
                   out_alu_func, out_a, out_b, out_rd, e.func, e.a, e.b, e.rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t nul;
    nul = mk(ALU_NAND, 16'h0, 16'h0, 3'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    out_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and first-cycle ready.
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal",   32'(illegal), 32'd0);
    chk("rst_out_a",     32'(out_a), 32'd0);
    chk("rst_out_b",     32'(out_b), 32'd0);
    chk("rst_out_rd",    32'(out_rd), 32'd0);
    chk("rst_func",      32'(out_alu_func), 32'(ALU_NAND));
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    step();

    // ADDI r1,r0,5 -> ADD 0,5 rd1.
    send(enc_i(OP_ADDI, 3'd1, 3'd0, 6'd5), 1'b1, mk(ALU_ADD, 16'd0, 16'd5, 3'd1), w);

    // ADD r2,r1,r1 stalls on pending r1 until writeback, then bypasses 5.
    in_instr = enc_r(OP_ADD, 3'd2, 3'd1, 3'd1);
    @(negedge clk);
    chk("addi_out_valid", 32'(out_valid), 32'd1);
    chk("raw_stall0", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("raw_stall1", 32'(in_ready), 32'd0);
    step();
    wb_valid = 1'b1;
    wb_rd = 3'd1;
    wb_data = 16'd5;
    send(enc_r(OP_ADD, 3'd2, 3'd1, 3'd1), 1'b1, mk(ALU_ADD, 16'd5, 16'd5, 3'd2), w);
    chk("raw_release_wait", 32'(w), 32'd0);
    in_valid = 1'b0;
    wb_rd = 3'd2;
    wb_data = 16'd10;
    step();
    wb_valid = 1'b0;

    // R0 writes are ignored, also as a same-cycle bypass.
    wb_valid = 1'b1;
    wb_rd = 3'd0;
    wb_data = 16'hFFFF;
    step();
    send(enc_r(OP_OR, 3'd3, 3'd0, 3'd0), 1'b1, mk(ALU_OR, 16'd0, 16'd0, 3'd3), w);
    in_valid = 1'b0;
    wb_rd = 3'd3;
    wb_data = 16'h1234;
    step();
    wb_valid = 1'b0;
    step();

    // Backpressure: first output held, second waits, then both delivered once.
    out_ready = 1'b0;
    send(enc_i(OP_ADDI, 3'd5, 3'd1, 6'd3), 1'b1, mk(ALU_ADD, 16'd5, 16'd3, 3'd5), w);
    in_instr = enc_r(OP_XOR, 3'd6, 3'd1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid",    32'(out_valid), 32'd1);
      chk("hold_a",        32'(out_a), 32'd5);
      chk("hold_b",        32'(out_b), 32'd3);
      chk("hold_rd",       32'(out_rd), 32'd5);
      chk("hold_func",     32'(out_alu_func), 32'(ALU_ADD));
      step();
    end
    out_ready = 1'b1;
    send(enc_r(OP_XOR, 3'd6, 3'd1, 3'd2), 1'b1, mk(ALU_XOR, 16'd5, 16'd10, 3'd6), w);
    chk("release_wait", 32'(w), 32'd0);
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("drop_valid", 32'(out_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 3'd5;
    wb_data = 16'd8;
    step();
    wb_rd = 3'd6;
    wb_data = 16'd15;
    step();
    wb_valid = 1'b0;

    // Illegal opcode: consumed silently, sticky flag, next legal issues.
    send(16'hC000, 1'b0, nul, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_set",       32'(illegal), 32'd1);
    chk("illegal_no_output", 32'(out_valid), 32'd0);
    step();
    send(enc_r(OP_AND, 3'd7, 3'd1, 3'd2), 1'b1, mk(ALU_AND, 16'd5, 16'd10, 3'd7), w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    step();

    // Reset with a held output and r4 pending; writeback and transfer attempted too.
    out_ready = 1'b0;
    send(enc_i(OP_ADDI, 3'd4, 3'd0, 6'd7), 1'b1, mk(ALU_ADD, 16'd0, 16'd7, 3'd4), w);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 3'd1;
    wb_data = 16'h0055;
    in_valid = 1'b1;
    in_instr = enc_i(OP_ADDI, 3'd6, 3'd0, 6'd1);
    step();
    rst = 1'b0;
    wb_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_illegal",   32'(illegal), 32'd0);
    chk("rst2_out_rd",    32'(out_rd), 32'd0);
    step();
    send(enc_r(OP_ADD, 3'd5, 3'd4, 3'd1), 1'b1, mk(ALU_ADD, 16'd0, 16'd0, 3'd5), w);
    chk("rst2_no_stall", 32'(w), 32'd0);

    // Back-to-back independent issue at one per cycle, with sign extension.
    send(enc_i(OP_ADDI, 3'd1, 3'd0, 6'h3F), 1'b1, mk(ALU_ADD, 16'd0, 16'hFFFF, 3'd1), w);
    chk("b2b_0", 32'(w), 32'd0);
    send(enc_i(OP_ADDI, 3'd2, 3'd0, 6'h20), 1'b1, mk(ALU_ADD, 16'd0, 16'hFFE0, 3'd2), w);
    chk("b2b_1", 32'(w), 32'd0);
    send(enc_r(OP_SUB, 3'd3, 3'd0, 3'd0), 1'b1, mk(ALU_SUB, 16'd0, 16'd0, 3'd3), w);
    chk("b2b_2", 32'(w), 32'd0);
    send(enc_r(OP_SR, 3'd6, 3'd0, 3'd0), 1'b1, mk(ALU_SR, 16'd0, 16'd0, 3'd6), w);
    chk("b2b_3", 32'(w), 32'd0);
    in_valid = 1'b0;

    repeat (3) step();
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter NREGS, default 8, giving the number of architectural 16-bit registers; register indices are 3 bits wide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_instr (input, 16): the instruction handshake from fetch.
REQ-005 SHALL have ports out_valid (input/output as follows: output, 1) and out_ready (input, 1): the issue handshake to execute.
REQ-006 SHALL have output port out_alu_func, type alu_func_e: the operation to perform.
REQ-007 SHALL have output ports out_a (16) and out_b (16): the ALU operands.
REQ-008 SHALL have output port out_rd (3): the destination register index.
REQ-009 SHALL have input ports wb_valid (1), wb_rd (3) and wb_data (16): the writeback from execute.
REQ-010 SHALL have output port illegal (1): a sticky illegal-opcode flag.

Function
REQ-011 Instruction format SHALL be: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0].
REQ-012 Opcodes 0-8 SHALL map to NAND, AND, NOR, OR, ADD, SUB, XOR, SL, SR, with a=R[rs1] and b=R[rs2].
REQ-013 Opcode 9 (ADDI) SHALL issue ADD with a=R[rs1] and b=sign-extended imm6.
REQ-014 Opcodes 10-15 SHALL be illegal: when accepted, the instruction is consumed, no output is issued, illegal is set, and it stays set until rst.
REQ-015 Reads of R0 SHALL return 0; writebacks to R0 SHALL be ignored.
REQ-016 A scoreboard with one pending bit per register SHALL be set for rd when an instruction with rd!=0 is accepted, and cleared when wb_valid is asserted for that rd.
REQ-017 Hazard SHALL be: in_valid and the pending bit is set for rs1, for rs2 (register form only), or for rd (WAW), after applying this cycle's writeback clear.
REQ-018 in_ready SHALL equal (~out_valid | out_ready) & ~hazard.
REQ-019 A transfer SHALL occur when in_valid & in_ready; a legal transfer registers the outputs, and out_valid rises on the next edge (1-cycle latency).
REQ-020 Holding behaviour: while out_valid & ~out_ready, all out_* signals SHALL hold stable.
REQ-021 Holding behaviour: out_valid SHALL drop on the edge after an out_ready handshake unless a new transfer occurs in the same cycle.
REQ-022 Writeback bypass: when wb_valid and wb_rd equals a source register in the accept cycle, the operand SHALL be taken from wb_data.
REQ-023 Same-edge set and clear on one register (accept with rd=X and wb_rd=X): the pending bit SHALL end set.
REQ-024 Back-to-back independent instructions SHALL sustain 1 per cycle when out_ready=1.

Reset
REQ-025 On rst, out_valid, illegal, all pending bits and all registers SHALL be 0.
REQ-026 On rst, out_a, out_b and out_rd SHALL be 0, and out_alu_func SHALL be NAND.
REQ-027 rst asserted mid-operation SHALL discard any held output and take precedence over any simultaneous transfer or writeback.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts, given in_valid=0.

Structure
REQ-029 alu_func_e (NAND=0 … SR=8), the opcode constants and the instruction field-position constants SHALL live in the shared package cpu_pkg.
REQ-030 The register array SHALL be a sub-module regfile: 2 combinational read ports, 1 synchronous write port, R0 hardwired to zero.
REQ-031 The scoreboard, hazard logic and output register SHALL reside in operand_fetch.

Verification
REQ-032 Reset, then ADDI r1,r0,5 with out_ready=1 -> next cycle out_valid=1, ADD, a=0, b=5, rd=1.
REQ-033 ADDI r1 issued and no writeback, then ADD r2,r1,r1 presented -> in_ready=0 until wb_valid with rd=1 and data 5; in that cycle it is accepted, giving a=5, b=5.
REQ-034 wb_valid with rd=0 and data 0xFFFF, then OR r3,r0,r0 -> a=0, b=0.
REQ-035 Two outputs issued with out_ready=0 -> first output held stable, in_ready=0; raise out_ready -> second output on the following cycle, no loss or duplication.
REQ-036 Opcode 0xC accepted -> illegal=1, out_valid stays 0; next legal instruction issues normally; illegal remains set until rst.
REQ-037 rst asserted while out_valid=1 and r4 pending -> out_valid=0, pending cleared, and ADD r5,r4,r4 is accepted immediately after, giving a=0.
